// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum adder: FSM state type, default
// packet geometry and packet field-extract helpers.
package psum_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SUM     = 2'd1,
        SEND    = 2'd2
    } psum_state_t;

    localparam int DEF_PKT_W   = 40;
    localparam int DEF_DATA_W  = 13;
    localparam int FIELD_MAX_W = 64;

    // Callers zero-extend their packet to FIELD_MAX_W and cast the result back.
    function automatic logic [FIELD_MAX_W-1:0] pkt_data(input logic [FIELD_MAX_W-1:0] pkt,
                                                        input int data_w);
        logic [FIELD_MAX_W-1:0] mask;
        mask = {FIELD_MAX_W{1'b1}} >> (FIELD_MAX_W - data_w);
        return pkt & mask;
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] pkt_hdr(input logic [FIELD_MAX_W-1:0] pkt,
                                                       input int data_w);
        return pkt >> data_w;
    endfunction

endpackage

// File: rtl/psum_adder_n_if.sv
// Handshake bundle of the partial-sum adder: per-lane input streams, the
// result stream and the sticky header-error flag.
interface psum_adder_n_if
    import psum_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int PKT_W  = DEF_PKT_W
);
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*PKT_W-1:0] in_pkt;
    logic                    out_valid;
    logic                    out_ready;
    logic [PKT_W-1:0]        out_pkt;
    logic                    err_hdr;

    modport master (
        output in_valid, in_pkt, out_ready,
        input  in_ready, out_valid, out_pkt, err_hdr
    );

    modport slave (
        input  in_valid, in_pkt, out_ready,
        output in_ready, out_valid, out_pkt, err_hdr
    );
endinterface

// File: rtl/psum_lane_capture.sv
// One input lane: holds the captured packet, the captured flag and a
// registered ready that is low from reset until the first clock after release.
module psum_lane_capture
    import psum_pkg::*;
#(
    parameter int PKT_W = DEF_PKT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [PKT_W-1:0] pkt_i,
    input  logic             collect_nxt_i,
    input  logic             clr_i,
    output logic             ready_o,
    output logic             cap_nxt_o,
    output logic [PKT_W-1:0] pkt_o
);
    logic             take;
    logic             cap_q, cap_d;
    logic             rdy_q, rdy_d;
    logic [PKT_W-1:0] pkt_q;

    // Kept as separate assigns so cap_d never depends on collect_nxt_i.
    assign take  = valid_i & rdy_q;
    assign cap_d = clr_i ? 1'b0 : (cap_q | take);
    assign rdy_d = collect_nxt_i & ~cap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            rdy_q <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (take) pkt_q <= pkt_i;
    end

    assign ready_o   = rdy_q;
    assign cap_nxt_o = cap_d;
    assign pkt_o     = pkt_q;
endmodule

// File: rtl/psum_adder_n.sv
// Joins NUM_IN partial-sum lanes, accumulates ACC_CNT sets and emits one packet.
// Define PSUM_SAT_EN to saturate the output field instead of wrapping it.
module psum_adder_n
    import psum_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int PKT_W   = DEF_PKT_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_CNT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    psum_adder_n_if.slave bus
);
    localparam int HDR_W = PKT_W - DATA_W;
    localparam int ACC_W = DATA_W + $clog2(NUM_IN * ACC_CNT) + 1;
    localparam int CNT_W = $clog2(ACC_CNT + 1);

    psum_state_t      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, set_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HDR_W-1:0] hdr_q, hdr_d, ref_hdr;
    logic             err_q, err_d;
    logic             ov_q, ov_d;
    logic [PKT_W-1:0] opkt_q, opkt_d;
    logic [NUM_IN-1:0] cap_nxt, rdy, hdr_bad;
    logic [PKT_W-1:0] cap_pkt [NUM_IN];
    logic             collect_nxt, clr;

    function automatic logic [DATA_W-1:0] clip_field(input logic [ACC_W-1:0] a);
`ifdef PSUM_SAT_EN
        logic [ACC_W-1:0] field_max;
        field_max = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
        return (a > field_max) ? {DATA_W{1'b1}} : DATA_W'(a);
`else
        return DATA_W'(a);
`endif
    endfunction

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        psum_lane_capture #(.PKT_W(PKT_W)) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_i      (bus.in_valid[g]),
            .pkt_i        (bus.in_pkt[g*PKT_W +: PKT_W]),
            .collect_nxt_i(collect_nxt),
            .clr_i        (clr),
            .ready_o      (rdy[g]),
            .cap_nxt_o    (cap_nxt[g]),
            .pkt_o        (cap_pkt[g])
        );
    end

    assign clr         = (state_q == SUM);
    assign collect_nxt = (state_d == COLLECT);

    // On the first set of a packet, lane 0's captured header becomes the reference.
    always_comb begin
        set_sum = '0;
        hdr_bad = '0;
        ref_hdr = (cnt_q == '0) ? HDR_W'(pkt_hdr(FIELD_MAX_W'(cap_pkt[0]), DATA_W)) : hdr_q;
        for (int i = 0; i < NUM_IN; i++) begin
            set_sum    = set_sum + ACC_W'(pkt_data(FIELD_MAX_W'(cap_pkt[i]), DATA_W));
            hdr_bad[i] = (HDR_W'(pkt_hdr(FIELD_MAX_W'(cap_pkt[i]), DATA_W)) != ref_hdr);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        err_d   = err_q;
        ov_d    = ov_q;
        opkt_d  = opkt_q;
        unique case (state_q)
            COLLECT: if (&cap_nxt) state_d = SUM;
            SUM: begin
                acc_d = acc_q + set_sum;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                hdr_d = ref_hdr;
                if (|hdr_bad) err_d = 1'b1;
                if (cnt_d == CNT_W'(ACC_CNT)) begin
                    state_d = SEND;
                    ov_d    = 1'b1;
                    opkt_d  = {ref_hdr, clip_field(acc_d)};
                end else begin
                    state_d = COLLECT;
                end
            end
            SEND: if (bus.out_ready) begin
                state_d = COLLECT;
                acc_d   = '0;
                cnt_d   = '0;
                ov_d    = 1'b0;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            opkt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            opkt_q  <= opkt_d;
        end
    end

    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov_q;
    assign bus.out_pkt   = opkt_q;
    assign bus.err_hdr   = err_q;
endmodule

// File: doc/psum_adder_n.md
PSUM_ADDER_N -- requirements
Module: psum_adder_n

Interface
REQ-001 SHALL have parameter NUM_IN, default 2, meaning number of partial-sum input lanes (2..8).
REQ-002 SHALL have parameter PKT_W, default 40, meaning total packet width.
REQ-003 SHALL have parameter DATA_W, default 13, meaning unsigned partial-sum field width in packet bits [DATA_W-1:0].
REQ-004 SHALL have parameter ACC_CNT, default 1, meaning joined input sets accumulated per output packet (1..16).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  NUM_IN  per-lane packet valid.
REQ-008 SHALL have port in_ready  output  NUM_IN  per-lane packet accepted.
REQ-009 SHALL have port in_pkt  input  NUM_IN*PKT_W  lane i packet at bits [i*PKT_W +: PKT_W].
REQ-010 SHALL have port out_valid  output  1  result packet valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_pkt  output  PKT_W  header of lane 0 first set in [PKT_W-1:DATA_W], accumulated sum in [DATA_W-1:0].
REQ-013 SHALL have port err_hdr  output  1  sticky header-mismatch flag.

Function
REQ-014 SHALL transfer lane i on a cycle where in_valid[i] and in_ready[i] are both high; out transfer on out_valid and out_ready.
REQ-015 SHALL implement FSM states COLLECT, SUM, SEND; reset state COLLECT.
REQ-016 In COLLECT, in_ready[i] SHALL be high iff lane i not yet captured in the current set; lanes capture independently, in any order or all on one cycle.
REQ-017 Once all NUM_IN lanes are captured, SHALL enter SUM on the next cycle; in_ready SHALL be all-low in SUM and SEND.
REQ-018 SUM (one cycle) SHALL add all captured data fields to the accumulator, clear capture flags, increment set counter.
REQ-019 After SUM, if set counter reaches ACC_CNT, SHALL enter SEND; otherwise SHALL return to COLLECT.
REQ-020 Latency: out_valid SHALL rise exactly 2 cycles after the cycle the final lane of the final set is captured.
REQ-021 In SEND, out_valid and out_pkt SHALL stay stable until out_ready; on transfer accumulator and counter SHALL clear and state SHALL return to COLLECT the next cycle.
REQ-022 Header latched from lane 0 on first set's capture; any captured lane header differing from it SHALL set err_hdr, cleared only by reset.
REQ-023 Sum arithmetic SHALL use a DATA_W+$clog2(NUM_IN*ACC_CNT)+1-bit internal accumulator; overflow handling per REQ-027.

Reset
REQ-024 On rst_n low, SHALL asynchronously clear in_ready, out_valid, out_pkt, err_hdr, accumulator, counter, capture flags and FSM to COLLECT.
REQ-025 Reset mid-set or mid-SEND SHALL discard partial data; first in_ready high SHALL be the cycle after rst_n deasserts.

Configuration
REQ-026 Macro PSUM_SAT_EN SHALL select overflow mode.
REQ-027 Defined: output field SHALL saturate to 2^DATA_W-1 when accumulator exceeds it; undefined: output field SHALL be accumulator modulo 2^DATA_W.

Structure
REQ-028 Package psum_pkg SHALL hold the FSM state enum, default PKT_W/DATA_W constants and header/data field-extract helpers.
REQ-029 One sub-module psum_lane_capture SHALL hold a single lane's capture register, captured flag and ready generation, instantiated NUM_IN times.

Verification
REQ-030 NUM_IN=2, ACC_CNT=1: lane0 data 5, lane1 data 7, same cycle -> out_pkt data 12, out_valid 2 cycles later.
REQ-031 NUM_IN=4: lanes arrive at cycles 0,3,1,6 -> in_ready[i] drops after own capture; out_valid at cycle 8.
REQ-032 ACC_CNT=3, NUM_IN=2: sets (1,2),(3,4),(5,6) -> single output, data 21.
REQ-033 DATA_W=13: lanes 8000+500 -> 8191 with PSUM_SAT_EN, 308 without.
REQ-034 out_ready held low 10 cycles -> out_pkt stable, in_ready low; new inputs accepted cycle after transfer.
REQ-035 lane1 header differs from lane0 -> err_hdr high and sticky; rst_n pulse mid-SEND -> out_valid 0 and err_hdr 0 asynchronously.
